// File: rtl/video_effects_stream_ctrl.sv
// Avalon-ST wrapper around the video_effects core: sideband realignment, output FIFO, stats.
// Define VIDEO_FX_FRAME_LOCK_EN to freeze effect configuration per frame at SOP.
module video_effects_stream_ctrl #(
  parameter int FIFO_DEPTH   = 4,
  parameter int FRAME_PIXELS = 76800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_startofpacket,
  input  logic        in_endofpacket,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [4:0]  cfg_effect,
  input  logic [1:0]  cfg_delete_rgb,
  input  logic [1:0]  cfg_quantif_level,
  input  logic [15:0] cfg_color_key,
  input  logic [15:0] cfg_color_key_threshold,
  input  logic [15:0] cfg_color_substitute,
  output logic [4:0]  fx_effect,
  output logic [1:0]  fx_effect_delete_rgb,
  output logic [1:0]  fx_effect_quantif_level,
  output logic [15:0] fx_effect_color_key,
  output logic [15:0] fx_effect_color_key_threshold,
  output logic [15:0] fx_effect_color_substitute,
  output logic [15:0] fx_video_data_in,
  input  logic [15:0] fx_video_data_out,
  output logic [15:0] frame_count,
  output logic        err_len,
  output logic        err_sop,
  input  logic        status_clear
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [16:0] FP_W = 17'(FRAME_PIXELS);

  typedef enum logic {IDLE, IN_FRAME} state_t;

  logic acc;
  logic pend_q, sop_q, eop_q;
  logic [17:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [CW:0]   occ;
  logic push, pop;
  logic [17:0]   head;

  state_t state_q, state_d;
  logic [16:0] pix_q, pix_d, pix_inc;
  logic [15:0] fcnt_q, fcnt_d;
  logic        elen_q, elen_d;
  logic        esop_q, esop_d;
  logic        frame_end, len_bad;

  // Ready looks only at registered occupancy, counting the beat inside the core.
  assign occ      = {1'b0, cnt_q} + {{CW{1'b0}}, pend_q};
  assign in_ready = occ < DEPTH_W;
  assign acc      = in_valid & in_ready;

  assign fx_video_data_in = in_data;

  assign push = pend_q;
  assign pop  = out_valid & out_ready;
  assign head = mem_q[rd_ptr_q];

  assign out_valid         = cnt_q != '0;
  assign out_startofpacket = head[17];
  assign out_endofpacket   = head[16];
  assign out_data          = head[15:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= 1'b0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
    end else begin
      pend_q <= acc;
      if (acc) begin
        sop_q <= in_startofpacket;
        eop_q <= in_endofpacket;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {sop_q, eop_q, fx_video_data_out};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pix_q   <= '0;
      fcnt_q  <= '0;
      elen_q  <= 1'b0;
      esop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      fcnt_q  <= fcnt_d;
      elen_q  <= elen_d;
      esop_q  <= esop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    fcnt_d    = fcnt_q;
    elen_d    = elen_q;
    esop_d    = esop_q;
    frame_end = 1'b0;
    len_bad   = 1'b0;
    pix_inc   = (pix_q == '1) ? pix_q : pix_q + 17'd1;
    if (acc) begin
      if (in_startofpacket) begin
        if (state_q == IN_FRAME) esop_d = 1'b1;
        pix_d   = 17'd1;
        state_d = IN_FRAME;
        if (in_endofpacket) begin
          frame_end = 1'b1;
          len_bad   = FP_W != 17'd1;
        end
      end else if (state_q == IN_FRAME) begin
        pix_d = pix_inc;
        if (in_endofpacket) begin
          frame_end = 1'b1;
          len_bad   = pix_inc != FP_W;
        end
      end
    end
    if (frame_end) begin
      fcnt_d  = fcnt_q + 16'd1;
      state_d = IDLE;
      if (len_bad) elen_d = 1'b1;
    end
    if (status_clear) begin
      fcnt_d = '0;
      elen_d = 1'b0;
      esop_d = 1'b0;
    end
  end

  assign frame_count = fcnt_q;
  assign err_len     = elen_q;
  assign err_sop     = esop_q;

`ifdef VIDEO_FX_FRAME_LOCK_EN
  logic        lock;
  logic [4:0]  sh_eff_q;
  logic [1:0]  sh_del_q, sh_qnt_q;
  logic [15:0] sh_key_q, sh_thr_q, sh_sub_q;

  assign lock = acc & in_startofpacket;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_eff_q <= '0;
      sh_del_q <= '0;
      sh_qnt_q <= '0;
      sh_key_q <= '0;
      sh_thr_q <= '0;
      sh_sub_q <= '0;
    end else if (lock) begin
      sh_eff_q <= cfg_effect;
      sh_del_q <= cfg_delete_rgb;
      sh_qnt_q <= cfg_quantif_level;
      sh_key_q <= cfg_color_key;
      sh_thr_q <= cfg_color_key_threshold;
      sh_sub_q <= cfg_color_substitute;
    end
  end

  // SOP pixel sees the new settings in the same cycle they are captured.
  assign fx_effect                     = lock ? cfg_effect : sh_eff_q;
  assign fx_effect_delete_rgb          = lock ? cfg_delete_rgb : sh_del_q;
  assign fx_effect_quantif_level       = lock ? cfg_quantif_level : sh_qnt_q;
  assign fx_effect_color_key           = lock ? cfg_color_key : sh_key_q;
  assign fx_effect_color_key_threshold = lock ? cfg_color_key_threshold : sh_thr_q;
  assign fx_effect_color_substitute    = lock ? cfg_color_substitute : sh_sub_q;
`else
  assign fx_effect                     = cfg_effect;
  assign fx_effect_delete_rgb          = cfg_delete_rgb;
  assign fx_effect_quantif_level       = cfg_quantif_level;
  assign fx_effect_color_key           = cfg_color_key;
  assign fx_effect_color_key_threshold = cfg_color_key_threshold;
  assign fx_effect_color_substitute    = cfg_color_substitute;
`endif

endmodule

// File: tb/tb_video_effects_stream_ctrl.sv
// Scoreboard bench for video_effects_stream_ctrl with a 1-cycle inverting core model.
// Expected pixels come from a frame-level reference model of effect selection and statistics.
module tb_video_effects_stream_ctrl;

  localparam int FD = 4;
  localparam int FP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_startofpacket = 1'b0;
  logic        in_endofpacket = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_startofpacket, out_endofpacket, out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  cfg_effect = '0;
  logic [1:0]  cfg_delete_rgb = '0;
  logic [1:0]  cfg_quantif_level = '0;
  logic [15:0] cfg_color_key = '0;
  logic [15:0] cfg_color_key_threshold = '0;
  logic [15:0] cfg_color_substitute = '0;
  logic [4:0]  fx_effect;
  logic [1:0]  fx_effect_delete_rgb, fx_effect_quantif_level;
  logic [15:0] fx_effect_color_key, fx_effect_color_key_threshold;
  logic [15:0] fx_effect_color_substitute;
  logic [15:0] fx_video_data_in, fx_video_data_out;
  logic [15:0] frame_count;
  logic        err_len, err_sop;
  logic        status_clear = 1'b0;

  video_effects_stream_ctrl #(.FIFO_DEPTH(FD), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_startofpacket(in_startofpacket),
    .in_endofpacket(in_endofpacket), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_effect(cfg_effect), .cfg_delete_rgb(cfg_delete_rgb),
    .cfg_quantif_level(cfg_quantif_level), .cfg_color_key(cfg_color_key),
    .cfg_color_key_threshold(cfg_color_key_threshold),
    .cfg_color_substitute(cfg_color_substitute),
    .fx_effect(fx_effect), .fx_effect_delete_rgb(fx_effect_delete_rgb),
    .fx_effect_quantif_level(fx_effect_quantif_level),
    .fx_effect_color_key(fx_effect_color_key),
    .fx_effect_color_key_threshold(fx_effect_color_key_threshold),
    .fx_effect_color_substitute(fx_effect_color_substitute),
    .fx_video_data_in(fx_video_data_in), .fx_video_data_out(fx_video_data_out),
    .frame_count(frame_count), .err_len(err_len), .err_sop(err_sop),
    .status_clear(status_clear)
  );

  always #5 clk = ~clk;

  // Core stand-in: effect bit 4 inverts, one register of latency, no enable.
  logic [15:0] core_q = '0;
  always @(posedge clk) core_q <= fx_effect[4] ? ~fx_video_data_in : fx_video_data_in;
  assign fx_video_data_out = core_q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit lat_chk = 1'b0;
  bit rnd_bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        s;
    logic        e;
    logic [15:0] d;
    int          cyc;
  } exp_t;
  exp_t q[$];

  logic [4:0]  lock_eff = '0;
  logic [15:0] mfc = '0;
  bit          melen = 1'b0;
  bit          mesop = 1'b0;
  bit          minfr = 1'b0;
  int          mpc = 0;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at cycle %0d", n, a, e, cyc);
    end
  endfunction

  function automatic void push_exp(logic [15:0] d, logic s, logic e);
    exp_t x;
    logic [4:0] eff;
    if (s) lock_eff = cfg_effect;
`ifdef VIDEO_FX_FRAME_LOCK_EN
    eff = lock_eff;
`else
    eff = cfg_effect;
`endif
    x.d = eff[4] ? ~d : d;
    x.s = s;
    x.e = e;
    x.cyc = cyc;
    q.push_back(x);
    if (s) begin
      if (minfr) mesop = 1'b1;
      minfr = 1'b1;
      mpc = 1;
    end else if (minfr) begin
      mpc++;
    end
    if (minfr && e) begin
      mfc = mfc + 16'd1;
      if (mpc != FP) melen = 1'b1;
      minfr = 1'b0;
    end
  endfunction

  always @(negedge clk) begin : monitor
    exp_t x;
    if (reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        x = q.pop_front();
        chk("out_data", {16'd0, out_data}, {16'd0, x.d});
        chk("out_sop", {31'd0, out_startofpacket}, {31'd0, x.s});
        chk("out_eop", {31'd0, out_endofpacket}, {31'd0, x.e});
        if (lat_chk) chk("latency", cyc - x.cyc, 32'd2);
      end
    end
  end

  initial begin : bp_gen
    forever begin
      @(posedge clk);
      #1;
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic drive_cycle(input logic v, input logic [15:0] d,
                             input logic s, input logic e, output bit a);
    in_valid = v;
    in_data = d;
    in_startofpacket = s;
    in_endofpacket = e;
    @(negedge clk);
    a = v && in_ready;
    if (a) push_exp(d, s, e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic s, input logic e);
    bit a = 1'b0;
    int n = 0;
    while (!a && n < 200) begin
      drive_cycle(1'b1, d, s, e, a);
      n++;
    end
    if (!a) chk("send_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 16'h0, 1'b0, 1'b0, a);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", q.size(), 32'd0);
  endtask

  task automatic clear_status();
    status_clear = 1'b1;
    @(posedge clk);
    #1;
    status_clear = 1'b0;
    mfc = '0;
    melen = 1'b0;
    mesop = 1'b0;
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_frame_count"}, {16'd0, frame_count}, {16'd0, mfc});
    chk({tag, "_err_len"}, {31'd0, err_len}, {31'd0, melen});
    chk({tag, "_err_sop"}, {31'd0, err_sop}, {31'd0, mesop});
  endtask

  initial begin : stim
    bit a;
    int k;
    int len;
    logic [15:0] pix [4];
    pix[0] = 16'h0000;
    pix[1] = 16'h1234;
    pix[2] = 16'hFFFF;
    pix[3] = 16'hF800;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sop", {31'd0, out_startofpacket}, 32'd0);
    chk("rst_out_eop", {31'd0, out_endofpacket}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
    chk("rst_errs", {30'd0, err_len, err_sop}, 32'd0);
    chk("rst_fx_effect", {27'd0, fx_effect}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Streaming with inversion, latency checked on every beat.
    out_ready = 1'b1;
    cfg_effect = 5'b10000;
    lat_chk = 1'b1;
    for (int i = 0; i < 4; i++) send(pix[i], i == 0, i == 3);
    wait_drain();
    lat_chk = 1'b0;
    check_stats("stream");

    // Backpressure: only FIFO_DEPTH beats fit while the sink is stalled.
    cfg_effect = 5'b00000;
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      drive_cycle(1'b1, 16'hA000 + 16'(k), k == 0, k == 5, a);
      if (a) k++;
    end
    chk("bp_accepted", k, FD);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    while (k < 6) begin
      send(16'hA000 + 16'(k), k == 0, k == 5);
      k++;
    end
    wait_drain();
    check_stats("bp");
    clear_status();
    check_stats("bp_clear");

    // Mid-frame configuration change.
    cfg_effect = 5'b00000;
    send(16'h1111, 1'b1, 1'b0);
    send(16'h2222, 1'b0, 1'b0);
    cfg_effect = 5'b10000;
    send(16'h3333, 1'b0, 1'b0);
    send(16'h4444, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send(16'h5550 + 16'(i), i == 0, i == 3);
    wait_drain();
    check_stats("cfg");

    // Framing errors.
    clear_status();
    send(16'h0001, 1'b1, 1'b0);
    send(16'h0002, 1'b0, 1'b0);
    send(16'h0003, 1'b0, 1'b1);
    chk("short_err_len", {31'd0, err_len}, 32'd1);
    send(16'h0004, 1'b1, 1'b0);
    send(16'h0005, 1'b0, 1'b0);
    send(16'h0006, 1'b1, 1'b0);
    chk("mid_err_sop", {31'd0, err_sop}, 32'd1);
    for (int i = 1; i < 4; i++) send(16'h0010 + 16'(i), 1'b0, i == 3);
    wait_drain();
    check_stats("err");
    clear_status();
    check_stats("err_clear");

    // Randomised frames, gaps, config churn and sink stalls.
    rnd_bp = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : FP;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 4) == 0) cfg_effect = 5'($urandom);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        send(16'($urandom), i == 0 || $urandom_range(0, 30) == 0, i == len - 1);
      end
    end
    rnd_bp = 1'b0;
    #1;
    out_ready = 1'b1;
    wait_drain();
    check_stats("rand");

    // Asynchronous reset with three beats held in the FIFO.
    cfg_effect = 5'b00000;
    for (int i = 0; i < 4; i++) send(16'h7700 + 16'(i), i == 0, i == 3);
    wait_drain();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(16'h6600 + 16'(i), i == 0, 1'b0);
    idle(1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_frame_count", {16'd0, frame_count}, 32'd0);
    q.delete();
    mfc = '0;
    melen = 1'b0;
    mesop = 1'b0;
    minfr = 1'b0;
    lock_eff = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) send(16'h5A00 + 16'(i), i == 0, i == 3);
    wait_drain();
    check_stats("arst");

    // Frame counter wrap through one-pixel frames.
    clear_status();
    for (int i = 0; i < 65536; i++) send(16'($urandom), 1'b1, 1'b1);
    wait_drain();
    check_stats("wrap");
    chk("wrap_fc_zero", {16'd0, frame_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_effects_stream_ctrl.md
Name: video_effects_stream_ctrl

Overview:
Avalon-ST control stage wrapped around the video_effects core in the Nios video pipeline. It accepts RGB565 pixel streams with ready/valid handshake and SOP/EOP framing, and feeds pixels to the core. The core has a fixed 1-cycle latency and no enable, so this block re-aligns framing sidebands with the core's output and absorbs downstream backpressure in an output FIFO. It also freezes effect configuration per frame and reports frame statistics and framing errors.

Parameters:
FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 2.
FRAME_PIXELS, 76800, expected beats per frame (320x240), used for length check.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
in_data  in  16  sink pixel, RGB565
in_startofpacket  in  1  sink first pixel of frame
in_endofpacket  in  1  sink last pixel of frame
in_valid  in  1  sink beat valid
in_ready  out  1  sink ready
out_data  out  16  source pixel
out_startofpacket  out  1  source SOP
out_endofpacket  out  1  source EOP
out_valid  out  1  source valid
out_ready  in  1  source ready
cfg_effect  in  5  CSR effect enables
cfg_delete_rgb  in  2  CSR RGB delete select
cfg_quantif_level  in  2  CSR quantisation level
cfg_color_key  in  16  CSR chroma key
cfg_color_key_threshold  in  16  CSR chroma threshold
cfg_color_substitute  in  16  CSR substitute colour
fx_effect, fx_effect_delete_rgb, fx_effect_quantif_level, fx_effect_color_key, fx_effect_color_key_threshold, fx_effect_color_substitute  out  5/2/2/16/16/16  configuration to the core
fx_video_data_in  out  16  pixel to the core
fx_video_data_out  in  16  core result, 1 cycle after fx_video_data_in
frame_count  out  16  completed frames, wraps 0xFFFF->0
err_len  out  1  sticky: EOP arrived with pixel count != FRAME_PIXELS
err_sop  out  1  sticky: SOP arrived inside an open frame
status_clear  in  1  single-cycle clear of frame_count, err_len and err_sop

Behaviour:
- Accept: acc = in_valid & in_ready.
- in_ready = (fifo_count + pend) < FIFO_DEPTH, where pend is the 1-cycle in-flight flag. It is combinational on registered state only and does not depend on in_valid.
- fx_video_data_in = in_data (combinational).
- On acc, at the clock edge: pend<=1; capture sop_d<=in_startofpacket and eop_d<=in_endofpacket. If there is no acc, pend<=0.
- When pend=1, write {sop_d, eop_d, fx_video_data_out} to the FIFO in that cycle.
- Sink-to-source latency is 2 cycles when the FIFO is empty and out_ready=1.
- FIFO: out_valid = !empty; head drives out_* outputs. Pop on out_valid & out_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Never writes when full; guaranteed by the in_ready rule.
  - Output values are undefined while out_valid=0.
- Config shadow: six shadow registers.
  - On acc with in_startofpacket=1, shadow <= cfg_* at that edge.
  - fx_* config outputs = (acc & in_startofpacket) ? cfg_* : shadow, so the SOP pixel already uses the new configuration.
  - cfg_* changes mid-frame have no effect until the next SOP.
- Frame tracking: state IDLE or IN_FRAME; pix_cnt is 17 bits, saturating.
  - IDLE: acc & SOP -> IN_FRAME with pix_cnt=1. Beats without SOP are passed through uncounted.
  - IN_FRAME: acc increments pix_cnt.
  - IN_FRAME, acc & SOP: set err_sop and restart with pix_cnt=1.
  - acc & EOP: frame_count++. If the final count != FRAME_PIXELS, set err_len. Go to IDLE.
  - SOP & EOP on the same beat is a 1-pixel frame, handled by the rules above.
- status_clear has priority over a same-cycle increment or error set.
- Reset (asynchronous, any time), all values:
  - FIFO empty, pend=0, state IDLE, pix_cnt=0.
  - frame_count=0, err_len=0, err_sop=0.
  - shadow = all zero, so fx_effect=0 (core in bypass).
  - Outputs: out_valid=0, out_sop=0, out_eop=0, out_data=0.
  - in_ready=1 one cycle after reset release.
  - Beats in flight are discarded.

Optional Feature:
VIDEO_FX_FRAME_LOCK_EN.
- Defined: per-frame configuration shadowing as above.
- Undefined: no shadow registers; fx_* config outputs = cfg_* directly, and changes take effect on the next beat.
- Framing, FIFO and statistics behaviour are identical in both builds.

Test Plan:
- Streaming, no backpressure: FRAME_PIXELS=4, cfg_effect=5'b10000, frame 0x0000,0x1234,0xFFFF,0xF800 with SOP on beat 0 and EOP on beat 3, out_ready=1.
  - Output 0xFFFF,0xEDCB,0x0000,0x07FF, with SOP/EOP aligned, 2-cycle latency.
  - frame_count=1, err_len=0.
- Backpressure: out_ready=0 for 10 cycles during a continuous stream.
  - Exactly FIFO_DEPTH beats are accepted, then in_ready=0.
  - On release, the beats drain in order with none lost or duplicated.
- Config lock (macro defined): cfg_effect changed 0->5'b10000 at pixel 2 of frame 1.
  - Frame 1 passes unmodified; frame 2 is inverted from its SOP pixel on.
- Framing errors: frame with EOP after 3 pixels (FRAME_PIXELS=4) -> err_len=1. SOP mid-frame -> err_sop=1. status_clear -> both 0 and frame_count=0.
- Asynchronous reset mid-frame with 3 beats in the FIFO:
  - Immediately out_valid=0 and frame_count=0.
  - After reset release, a new frame is processed correctly in bypass.
- Counter wrap: preload via 65536 one-pixel frames (SOP & EOP on the same beat) -> frame_count wraps to 0, err_len=1 (length 1 != FRAME_PIXELS).
